// File: rtl/assign_expand_pkg.sv
// Shared types for the range-assign expander: FSM states, per-range step
// direction, the descriptor layout and the default index width.
package assign_expand_pkg;

    localparam int IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // STEP_HOLD keeps an index fixed (scalar source broadcast across a sink range)
    typedef enum logic [1:0] {
        STEP_DEC  = 2'd0,
        STEP_INC  = 2'd1,
        STEP_HOLD = 2'd2
    } step_e;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] dst_msb;
        logic [IDX_W_DEF-1:0] dst_lsb;
        logic [IDX_W_DEF-1:0] src_msb;
        logic [IDX_W_DEF-1:0] src_lsb;
    } desc_t;

endpackage

// File: rtl/assign_expand_range_calc.sv
// Combinational range analysis: widths, step directions and accept decision.
// Scalar broadcast (1-bit source onto a wider sink) is accepted only with ASSIGN_EXPAND_BCAST_EN.
module assign_expand_range_calc
    import assign_expand_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [IDX_W-1:0] i_dst_msb,
    input  logic [IDX_W-1:0] i_dst_lsb,
    input  logic [IDX_W-1:0] i_src_msb,
    input  logic [IDX_W-1:0] i_src_lsb,
    output logic [IDX_W-1:0] o_rem_init,
    output step_e            o_dst_step,
    output step_e            o_src_step,
    output logic             o_accept
);

    logic             w_dst_dec;
    logic             w_src_dec;
    logic [IDX_W-1:0] w_dst_span;
    logic [IDX_W-1:0] w_src_span;
    logic [IDX_W:0]   w_dst_w;
    logic [IDX_W:0]   w_src_w;
    logic             w_bcast;

    assign w_dst_dec  = (i_dst_msb >= i_dst_lsb);
    assign w_src_dec  = (i_src_msb >= i_src_lsb);
    assign w_dst_span = w_dst_dec ? (i_dst_msb - i_dst_lsb) : (i_dst_lsb - i_dst_msb);
    assign w_src_span = w_src_dec ? (i_src_msb - i_src_lsb) : (i_src_lsb - i_src_msb);

    // One extra bit so a full-range width of 2**IDX_W cannot overflow
    assign w_dst_w = {1'b0, w_dst_span} + (IDX_W+1)'(1);
    assign w_src_w = {1'b0, w_src_span} + (IDX_W+1)'(1);

`ifdef ASSIGN_EXPAND_BCAST_EN
    assign w_bcast = (w_src_w == (IDX_W+1)'(1)) && (w_dst_w > (IDX_W+1)'(1));
`else
    assign w_bcast = 1'b0;
`endif

    assign o_accept   = (w_dst_w == w_src_w) || w_bcast;
    assign o_rem_init = w_dst_span;
    assign o_dst_step = w_dst_dec ? STEP_DEC : STEP_INC;
    assign o_src_step = w_bcast ? STEP_HOLD : (w_src_dec ? STEP_DEC : STEP_INC);

endmodule

// File: rtl/assign_range_expander.sv
// Expands sink[dm:dl] = source[sm:sl] into per-bit (dst, src) beats, msb end first.
// Scalar-broadcast support is enabled by defining ASSIGN_EXPAND_BCAST_EN.
module assign_range_expander
    import assign_expand_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_dst_msb,
    input  logic [IDX_W-1:0] in_dst_lsb,
    input  logic [IDX_W-1:0] in_src_msb,
    input  logic [IDX_W-1:0] in_src_lsb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_dst,
    output logic [IDX_W-1:0] out_src,
    output logic             out_last,
    output logic             err,
    output logic [7:0]       err_cnt
);

    state_e           r_state;
    logic [IDX_W-1:0] r_dst;
    logic [IDX_W-1:0] r_src;
    logic [IDX_W-1:0] r_rem;
    step_e            r_dst_step;
    step_e            r_src_step;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    logic [IDX_W-1:0] w_rem_init;
    step_e            w_dst_step;
    step_e            w_src_step;
    logic             w_accept;
    logic             w_take;
    logic             w_beat;

    assign_expand_range_calc #(
        .IDX_W (IDX_W)
    ) u_range_calc (
        .i_dst_msb  (in_dst_msb),
        .i_dst_lsb  (in_dst_lsb),
        .i_src_msb  (in_src_msb),
        .i_src_lsb  (in_src_lsb),
        .o_rem_init (w_rem_init),
        .o_dst_step (w_dst_step),
        .o_src_step (w_src_step),
        .o_accept   (w_accept)
    );

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    assign w_take = in_valid && (r_state == ST_IDLE);
    assign w_beat = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dst       <= '0;
            r_src       <= '0;
            r_rem       <= '0;
            r_dst_step  <= STEP_DEC;
            r_src_step  <= STEP_DEC;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_err <= 1'b0;
                    if (w_take) begin
                        if (w_accept) begin
                            r_dst       <= in_dst_msb;
                            r_src       <= in_src_msb;
                            r_rem       <= w_rem_init;
                            r_dst_step  <= w_dst_step;
                            r_src_step  <= w_src_step;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (w_rem_init == '0);
                            r_state     <= ST_EMIT;
                        end else begin
                            r_err <= 1'b1;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_beat) begin
                        // Indices are frozen on the last beat so they end exactly on dl/sl
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            case (r_dst_step)
                                STEP_DEC: r_dst <= r_dst - IDX_W'(1);
                                STEP_INC: r_dst <= r_dst + IDX_W'(1);
                                default:  r_dst <= r_dst;
                            endcase
                            case (r_src_step)
                                STEP_DEC: r_src <= r_src - IDX_W'(1);
                                STEP_INC: r_src <= r_src + IDX_W'(1);
                                default:  r_src <= r_src;
                            endcase
                            r_rem      <= r_rem - IDX_W'(1);
                            r_out_last <= (r_rem == IDX_W'(1));
                        end
                    end
                end
                ST_ERR: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_dst   = r_dst;
    assign out_src   = r_src;
    assign out_last  = r_out_last;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_assign_range_expander.sv
// Self-checking bench for assign_range_expander against a range-list reference model.
// Expectations follow ASSIGN_EXPAND_BCAST_EN when the bench is built with it.
module tb_assign_range_expander;

    localparam int IDX_W = 8;
    localparam int BW    = 2*IDX_W + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IDX_W-1:0] in_dst_msb = '0;
    logic [IDX_W-1:0] in_dst_lsb = '0;
    logic [IDX_W-1:0] in_src_msb = '0;
    logic [IDX_W-1:0] in_src_lsb = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDX_W-1:0] out_dst;
    logic [IDX_W-1:0] out_src;
    logic             out_last;
    logic             err;
    logic [7:0]       err_cnt;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [BW-1:0] exp_q[$];
    bit            exp_err;
    int            model_err_cnt = 0;

    assign_range_expander #(.IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dst_msb (in_dst_msb),
        .in_dst_lsb (in_dst_lsb),
        .in_src_msb (in_src_msb),
        .in_src_lsb (in_src_lsb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dst    (out_dst),
        .out_src    (out_src),
        .out_last   (out_last),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference: list every (last, dst, src) tuple the assign implies, or flag a rejection
    function automatic void model_desc(input int dm, input int dl, input int sm, input int sl);
        int wd;
        int ws;
        bit bc;
        wd = ((dm >= dl) ? (dm - dl) : (dl - dm)) + 1;
        ws = ((sm >= sl) ? (sm - sl) : (sl - sm)) + 1;
        bc = 1'b0;
`ifdef ASSIGN_EXPAND_BCAST_EN
        bc = (ws == 1) && (wd > 1);
`endif
        exp_q.delete();
        if ((wd != ws) && !bc) begin
            exp_err = 1'b1;
            model_err_cnt = (model_err_cnt < 255) ? model_err_cnt + 1 : 255;
            return;
        end
        exp_err = 1'b0;
        for (int k = 0; k < wd; k++) begin
            int d;
            int s;
            logic [BW-1:0] e;
            d = (dm >= dl) ? dm - k : dm + k;
            s = bc ? sm : ((sm >= sl) ? sm - k : sm + k);
            e = {(k == wd - 1), IDX_W'(d), IDX_W'(s)};
            exp_q.push_back(e);
        end
    endfunction

    task automatic scramble_inputs();
        in_valid   = 1'($urandom_range(0, 1));
        in_dst_msb = IDX_W'($urandom);
        in_dst_lsb = IDX_W'($urandom);
        in_src_msb = IDX_W'($urandom);
        in_src_lsb = IDX_W'($urandom);
    endtask

    task automatic run_desc(input int dm, input int dl, input int sm, input int sl,
                            input int stall_beat, input int stall_len, input bit rand_ready,
                            input string name);
        int beat;
        int stall;
        int budget;
        beat  = 0;
        stall = 0;
        model_desc(dm, dl, sm, sl);
        @(negedge clk);
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL %s in_ready before accept: got %b exp 1", name, in_ready);
        end
        in_valid   = 1'b1;
        in_dst_msb = IDX_W'(dm);
        in_dst_lsb = IDX_W'(dl);
        in_src_msb = IDX_W'(sm);
        in_src_lsb = IDX_W'(sl);
        @(negedge clk);
        scramble_inputs();
        if (exp_err) begin
            vec_cnt++;
            if ({err, out_valid, in_ready, err_cnt} !== {1'b1, 1'b0, 1'b0, 8'(model_err_cnt)}) begin
                miss_cnt++;
                $display("FAIL %s err pulse: got err=%b ov=%b ir=%b cnt=%0d exp err=1 ov=0 ir=0 cnt=%0d",
                         name, err, out_valid, in_ready, err_cnt, model_err_cnt);
            end
            @(negedge clk);
            in_valid = 1'b0;
            vec_cnt++;
            if ({err, out_valid, in_ready, err_cnt} !== {1'b0, 1'b0, 1'b1, 8'(model_err_cnt)}) begin
                miss_cnt++;
                $display("FAIL %s err end: got err=%b ov=%b ir=%b cnt=%0d exp err=0 ov=0 ir=1 cnt=%0d",
                         name, err, out_valid, in_ready, err_cnt, model_err_cnt);
            end
            return;
        end
        budget = 300;
        while (exp_q.size() > 0 && budget > 0) begin
            budget--;
            vec_cnt++;
            if (out_valid !== 1'b1 || err !== 1'b0 || {out_last, out_dst, out_src} !== exp_q[0]) begin
                miss_cnt++;
                $display("FAIL %s beat %0d: got ov=%b err=%b last/dst/src=%h exp ov=1 err=0 %h",
                         name, beat, out_valid, err, {out_last, out_dst, out_src}, exp_q[0]);
            end
            if (beat == stall_beat && stall < stall_len) begin
                out_ready = 1'b0;
                stall++;
            end else if (rand_ready) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            scramble_inputs();
            if (out_ready) begin
                void'(exp_q.pop_front());
                beat++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (budget == 0) begin
            miss_cnt++;
            $display("FAIL %s timeout: %0d beats still expected", name, exp_q.size());
        end
        vec_cnt++;
        if ({out_valid, in_ready, err} !== 3'b010) begin
            miss_cnt++;
            $display("FAIL %s after last: got ov/ir/err=%b exp 010", name, {out_valid, in_ready, err});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({out_valid, out_last, out_dst, out_src, err, err_cnt} !== '0) begin
            miss_cnt++;
            $display("FAIL reset_vals: got ov=%b last=%b dst=%0d src=%0d err=%b cnt=%0d exp all 0",
                     out_valid, out_last, out_dst, out_src, err, err_cnt);
        end
        rst_n = 1'b1;
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL reset_ready: got %b exp 1", in_ready);
        end
        model_err_cnt = 0;
    endtask

    task automatic test_basic();
        run_desc(3, 2, 3, 2, -1, 0, 1'b0, "basic_2bit");
    endtask

    task automatic test_single_and_ascend();
        run_desc(1, 1, 3, 3, -1, 0, 1'b0, "single_bit");
        run_desc(0, 3, 7, 4, -1, 0, 1'b0, "mixed_dir");
    endtask

    task automatic test_mismatch();
        run_desc(3, 0, 1, 0, -1, 0, 1'b0, "mismatch");
    endtask

    task automatic test_broadcast();
        run_desc(3, 0, 5, 5, -1, 0, 1'b0, "broadcast");
    endtask

    task automatic test_stall();
        run_desc(3, 0, 3, 0, 1, 3, 1'b0, "stall_beat2");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            int w;
            int ws;
            int lo;
            int lo2;
            int dm;
            int dl;
            int sm;
            int sl;
            w  = $urandom_range(1, 8);
            ws = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : w;
            lo  = $urandom_range(0, 256 - w);
            lo2 = $urandom_range(0, 256 - ws);
            if ($urandom_range(0, 1) == 1) begin dm = lo + w - 1; dl = lo; end
            else begin dm = lo; dl = lo + w - 1; end
            if ($urandom_range(0, 1) == 1) begin sm = lo2 + ws - 1; sl = lo2; end
            else begin sm = lo2; sl = lo2 + ws - 1; end
            run_desc(dm, dl, sm, sl, -1, 0, 1'b1, "random");
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) begin
            run_desc(3, 0, 1, 0, -1, 0, 1'b0, "saturate");
        end
        vec_cnt++;
        if (err_cnt !== 8'd255) begin
            miss_cnt++;
            $display("FAIL err_cnt_sat: got %0d exp 255", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        model_desc(3, 0, 3, 0);
        @(negedge clk);
        in_valid   = 1'b1;
        in_dst_msb = IDX_W'(3);
        in_dst_lsb = IDX_W'(0);
        in_src_msb = IDX_W'(3);
        in_src_lsb = IDX_W'(0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            vec_cnt++;
            if (out_valid !== 1'b1 || {out_last, out_dst, out_src} !== exp_q[b]) begin
                miss_cnt++;
                $display("FAIL rst_mid beat %0d: got ov=%b %h exp ov=1 %h",
                         b, out_valid, {out_last, out_dst, out_src}, exp_q[b]);
            end
            if (b == 0) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        model_err_cnt = 0;
        vec_cnt++;
        if ({out_valid, in_ready, out_last, out_dst, out_src, err, err_cnt} !== {2'b01, {(BW + 9){1'b0}}}) begin
            miss_cnt++;
            $display("FAIL rst_mid state: got ov=%b ir=%b last=%b dst=%0d src=%0d err=%b cnt=%0d exp ir=1 rest 0",
                     out_valid, in_ready, out_last, out_dst, out_src, err, err_cnt);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vec_cnt++;
            if ({out_valid, in_ready, err} !== 3'b010) begin
                miss_cnt++;
                $display("FAIL rst_mid after: got ov/ir/err=%b exp 010", {out_valid, in_ready, err});
            end
        end
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_and_ascend();
        test_mismatch();
        test_broadcast();
        test_stall();
        test_back_to_back();
        test_err_saturate();
        test_reset_mid();
        run_desc(5, 2, 9, 12, -1, 0, 1'b0, "post_reset");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/assign_range_expander.md
ASSIGN_RANGE_EXPANDER -- requirements
Module: assign_range_expander

Interface
REQ-001 Parameter IDX_W, default 8, bit-index width of every index field.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  range-assign descriptor present.
REQ-005 in_ready  output  1  descriptor accepted when in_valid && in_ready.
REQ-006 in_dst_msb, in_dst_lsb  input  IDX_W each  sink range bounds.
REQ-007 in_src_msb, in_src_lsb  input  IDX_W each  source range bounds.
REQ-008 out_valid  output  1  per-bit connection beat present.
REQ-009 out_ready  input  1  beat consumed when out_valid && out_ready.
REQ-010 out_dst, out_src  output  IDX_W each  sink bit index, source bit index of beat.
REQ-011 out_last  output  1  final beat of current descriptor.
REQ-012 err  output  1  one-cycle pulse: descriptor rejected.
REQ-013 err_cnt  output  8  count of rejected descriptors.

Function
REQ-014 The block SHALL expand one range assign (sink[dm:dl] = source[sm:sl]) into per-bit beats, ordered from the msb end toward the lsb end of each range.
REQ-015 Widths SHALL be Wd=|dm-dl|+1, Ws=|sm-sl|+1, computed at IDX_W+1 bits unsigned; the per-range step SHALL be -1 if msb>=lsb, else +1, independently for sink and source.
REQ-016 FSM states SHALL be IDLE, EMIT, ERR; in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE, accept with Wd==Ws: load dst=dm, src=sm, remaining=Wd-1, go EMIT; out_valid SHALL rise the cycle after acceptance (latency 1).
REQ-018 EMIT: out_valid=1; out_last=1 iff remaining==0; on beat handshake, non-last: dst+=dst step, src+=src step, remaining-=1; last: go IDLE.
REQ-019 out_dst, out_src, out_last SHALL hold stable while out_valid && !out_ready.
REQ-020 IDLE, accept with Wd!=Ws (width-step mismatch, not covered by REQ-031): go ERR; ERR SHALL assert err for exactly one cycle, increment err_cnt (saturate at 255), emit no beats, return to IDLE.
REQ-021 Single-bit descriptors (Wd==Ws==1) SHALL produce exactly one beat with out_last=1.
REQ-022 Index arithmetic SHALL never wrap: the last beat lands exactly on dl/sl; no index update after the last beat.
REQ-023 in_* inputs SHALL be ignored outside IDLE; input changes during EMIT SHALL not affect beats.

Reset
REQ-024 rst_n low at a clock edge SHALL force IDLE, out_valid=0, out_last=0, out_dst=0, out_src=0, err=0, err_cnt=0, remaining=0.
REQ-025 in_ready SHALL be 1 in the first cycle after rst_n returns high.
REQ-026 Reset during EMIT or ERR SHALL abort the descriptor; no further beat or err pulse for it.

Configuration
REQ-027 Macro ASSIGN_EXPAND_BCAST_EN SHALL control scalar-broadcast support.
REQ-028 With ASSIGN_EXPAND_BCAST_EN defined: Ws==1 && Wd>1 SHALL be accepted; Wd beats emitted, out_src constant at sm, dst stepping per REQ-018.
REQ-029 Without it: that case SHALL be treated as a mismatch per REQ-020.
REQ-030 All other behaviour SHALL be identical in both builds.
REQ-031 REQ-020 SHALL not apply to the broadcast case when the macro is defined.

Structure
REQ-032 Package assign_expand_pkg SHALL hold the state enum (IDLE/EMIT/ERR), the descriptor struct (dst_msb, dst_lsb, src_msb, src_lsb), and the default IDX_W constant.
REQ-033 Sub-module assign_expand_range_calc (combinational) SHALL compute widths, step directions and the accept/mismatch decision; the FSM, index registers and counter stay in the top.

Verification
REQ-034 dm=3,dl=2,sm=3,sl=2, out_ready=1 -> beats (3,3),(2,2); out_last on 2nd; in_ready back to 1 next cycle.
REQ-035 dm=1,dl=1,sm=3,sl=3 -> single beat (1,3), out_last=1; then dm=0,dl=3,sm=7,sl=4 -> (0,7),(1,6),(2,5),(3,4).
REQ-036 dm=3,dl=0,sm=1,sl=0 -> no beats, err high exactly 1 cycle, err_cnt=1; 256 such -> err_cnt=255.
REQ-037 dm=3,dl=0,sm=5,sl=5 -> with macro: beats (3,5),(2,5),(1,5),(0,5); without: err pulse, err_cnt=1.
REQ-038 dm=3,dl=0,sm=3,sl=0 with out_ready low 3 cycles on beat 2 -> (2,2) held stable 4 cycles, no beat lost or duplicated.
REQ-039 rst_n low during beat 2 of a 4-beat descriptor -> next cycle out_valid=0, in_ready=1, err_cnt=0, no remaining beats.
